// File: rtl/tx_arb_pkg.sv
// Shared types and parameter defaults for the TX FIFO arbiter.
package tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_MAX_BURST  = 16;

endpackage

// File: rtl/tx_fifo_arbiter_rr_select.sv
// Combinational round-robin pick: first valid requester searching upward
// from (ptr+1) mod N.
module rr_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!any_valid && valid[IW'((ptr + off) % N)]) begin
        any_valid = 1'b1;
        winner    = IW'((ptr + off) % N);
      end
    end
  end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter moving requester packets into a TX FIFO, bursts
// capped at MAX_BURST. Define TX_ARB_PRIO0_EN to give requester 0 priority.
module tx_fifo_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk_tx_arb,
  input  logic                          rst_tx_arb,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] grant_nxt;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;
  logic [GW-1:0] rr_winner, winner;
  logic          any_valid;

  rr_select #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_rr_select (
    .valid     (req_valid),
    .ptr       (last_grant),
    .winner    (rr_winner),
    .any_valid (any_valid)
  );

`ifdef TX_ARB_PRIO0_EN
  assign winner = req_valid[0] ? '0 : rr_winner;
`else
  assign winner = rr_winner;
`endif

  always_ff @(posedge clk_tx_arb) begin
    if (rst_tx_arb) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Handshake outputs are gated by reset so an aborted packet writes nothing.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant_id;
    burst_cnt_nxt  = burst_cnt;
    req_ready      = '0;
    fifo_wr        = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = XFER;
          grant_nxt = winner;
        end
      end
      XFER: begin
        if (!rst_tx_arb) begin
          req_ready[grant_id] = !fifo_full;
          fifo_wr             = req_valid[grant_id] & !fifo_full;
        end
        if (fifo_wr) begin
          if (req_last[grant_id] || (burst_cnt == BURST_LAST)) begin
            state_nxt      = IDLE;
            burst_cnt_nxt  = '0;
            last_grant_nxt = grant_id;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy = (state == XFER);

endmodule

// File: doc/tx_fifo_arbiter.md
TX_FIFO_ARBITER -- requirements
Module: tx_fifo_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width in bits of one frame.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum number of frames per grant.
REQ-004 clk_tx_arb  in  1: SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_tx_arb  in  1: SHALL be a synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ: per-requester frame-valid.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH: requester i frame at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  in  NUM_REQ: marks the last frame of the requester's packet.
REQ-009 req_ready  out  NUM_REQ: per-requester accept.
REQ-010 fifo_full  in  1: TX FIFO full flag.
REQ-011 fifo_wr  out  1: TX FIFO write strobe.
REQ-012 fifo_data  out  DATA_WIDTH: frame to the TX FIFO.
REQ-013 grant_id  out  clog2(NUM_REQ): current or most recent grant owner.
REQ-014 busy  out  1: high while in XFER.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and XFER.
REQ-016 In IDLE with any req_valid high, the winner SHALL be the first valid requester searching upward from (last_grant+1) mod NUM_REQ; grant_id <= winner and state <= XFER on the next edge.
REQ-017 In IDLE, req_ready and fifo_wr SHALL be 0; arbitration costs exactly one cycle per grant.
REQ-018 In XFER, req_ready[grant_id] SHALL equal !fifo_full, and every other req_ready bit SHALL be 0.
REQ-019 In XFER, fifo_wr SHALL equal req_valid[grant_id] & req_ready[grant_id], and fifo_data SHALL equal the grant_id slice of req_data, combinationally, with zero latency.
REQ-020 Each beat (fifo_wr=1) SHALL increment the burst counter, which is clog2(MAX_BURST+1) bits wide, reset to 0, and cleared on XFER exit.
REQ-021 XFER SHALL exit to IDLE after a beat with req_last[grant_id]=1, or after the beat that brings the burst counter to MAX_BURST; last_grant <= grant_id on exit.
REQ-022 While fifo_full=1, no beat SHALL occur, and the counter and state SHALL hold.
REQ-023 If req_valid[grant_id] drops mid-packet, the block SHALL remain in XFER with no timeout.
REQ-024 When last and MAX_BURST coincide on one beat, a single exit SHALL occur.
REQ-025 Changes on non-granted req_valid bits SHALL have no effect during XFER.

Reset
REQ-026 On reset: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), grant_id=0, burst counter=0, busy=0.
REQ-027 fifo_wr and all req_ready bits SHALL be forced to 0 in any cycle with rst_tx_arb=1, including reset asserted mid-XFER (the packet is aborted; no partial beat is written).

Configuration
REQ-028 With macro TX_ARB_PRIO0_EN defined, requester 0 SHALL win every IDLE arbitration in which req_valid[0]=1; otherwise REQ-016 applies, and last_grant SHALL update on exit as normal.
REQ-029 Without TX_ARB_PRIO0_EN, arbitration SHALL be pure round-robin per REQ-016.

Structure
REQ-030 Package tx_arb_pkg SHALL hold the IDLE/XFER state typedef and the DATA_WIDTH, NUM_REQ and MAX_BURST defaults.
REQ-031 Round-robin selection SHALL live in one combinational sub-module, rr_select (inputs: valid mask and pointer; output: winner index and any_valid).

Verification
REQ-032 Reset, then req_valid=4'b0001 with a 3-frame packet 0x11,0x22,0x33 (last on 0x33) -> grant_id=0 after 1 cycle, fifo_wr high for 3 consecutive cycles with those data, then IDLE.
REQ-033 All four requesters valid, 1-frame packets -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-034 Requester 2 sends 20 frames without last, MAX_BURST=16 -> exit after frame 16; requester 3 (if valid) is granted next; requester 2 resumes later.
REQ-035 fifo_full=1 for 5 cycles mid-packet -> req_ready=0 and fifo_wr=0 for those 5 cycles; no frame is lost or duplicated afterward.
REQ-036 Reset asserted on the 2nd beat of a 4-frame packet -> fifo_wr=0 in that cycle; next cycle state=IDLE and grant_id=0.
REQ-037 With TX_ARB_PRIO0_EN defined, last_grant=0 and req_valid=4'b0011 -> requester 0 is granted again; without the macro, requester 1 is granted.
